// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // One extra bit so the counter can never wrap inside an operation.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_nxt, last;

    // Single full-subtractor cell working on the current LSBs.
    assign d      = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
    assign last   = (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: the shift registers are plain flops, not a memory, so they are cleared by reset like the rest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    br     <= br_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff <= {d, res_sr[WIDTH-1:1]};
                        bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the operand LSBs are the original MSBs and d is the result MSB.
                        ovf  <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on done.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, start, bin;
    logic [W-1:0] a, b, diff;
    logic         busy, done, bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];
    exp_t prev;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^W; ovf from the operand/result sign rule.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t e;
        int   r;
        r      = int'(ma) - int'(mb) - int'(mbin);
        e.diff = r[W-1:0];
        e.bout = (int'(ma) < int'(mb) + int'(mbin));
        e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", {24'b0, diff}, {24'b0, e.diff});
                check("bout", {31'b0, bout}, {31'b0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input bit noise);
        exp_t e;
        int   c;
        int   busy_n;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        e = model(ta, tb, tbin);
        sb.push_back(e);
        @(posedge clk);
        c = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("diff_held_on_accept", {24'b0, diff}, {24'b0, prev.diff});
                check("bout_held_on_accept", {31'b0, bout}, {31'b0, prev.bout});
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
            if (noise) begin
                start = 1'b1; a = 8'hFF; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_n++;
        end while (done !== 1'b1 && c < 40);
        check("done_latency", c, W + 1);
        check("busy_cycles", busy_n, W);
        @(negedge clk);
        start = 1'b0;
        check("done_single_cycle", {31'b0, done}, 32'd0);
        check("diff_hold", {24'b0, diff}, {24'b0, e.diff});
        prev = e;
    endtask

    initial begin
        int c;
        int n;
        int dn;
        int pos[3];
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev = '{diff: '0, bout: 1'b0, ovf: 1'b0};
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_diff", {24'b0, diff}, 32'd0);
        check("reset_bout", {31'b0, bout}, 32'd0);
        rst_n = 1'b1;

        run_op(8'h35, 8'h12, 1'b0, 1'b0);
        run_op(8'h12, 8'h35, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h50, 8'h20, 1'b0, 1'b1);
        repeat (12) @(negedge clk);

        // Abort mid-operation with reset; the monitor flags any late done.
        @(negedge clk);
        a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_diff", {24'b0, diff}, 32'd0);
        check("abort_bout", {31'b0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", {31'b0, ovf}, 32'd0);
`endif
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("no_done_after_abort", dn, 0);
        prev = '{diff: '0, bout: 1'b0, ovf: 1'b0};
        run_op(8'h50, 8'h20, 1'b0, 1'b0);

        // Back-to-back with start held high.
        repeat (3) sb.push_back(model(8'h0A, 8'h03, 1'b0));
        @(negedge clk);
        a = 8'h0A; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        c = 0;
        n = 0;
        while (n < 3 && c < 60) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin
                pos[n] = c;
                n++;
                if (n == 3) start = 1'b0;
            end
        end
        check("b2b_pulses", n, 3);
        if (n == 3) begin
            check("b2b_first", pos[0], W + 1);
            check("b2b_gap1", pos[1] - pos[0], W + 2);
            check("b2b_gap2", pos[2] - pos[1], W + 2);
        end
        @(negedge clk);
        start = 1'b0;
        prev = model(8'h0A, 8'h03, 1'b0);
        repeat (3) @(negedge clk);

        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, the inverse counterpart of the team's combinational full adder.
- Computes diff = a - b - bin, LSB-first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency.
- Start/busy/done handshake toward the controlling block.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched when start is accepted.
- b  input  WIDTH  subtrahend; latched when start is accepted.
- bin  input  1  borrow-in; latched when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  difference; holds its value until the next accepted start.
- bout  output  1  final borrow-out; holds like diff.
- ovf  output  1  signed overflow (optional feature only).

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset:
  - rst_n low at a rising edge forces state to IDLE.
  - busy=0, done=0, diff=0, bout=0, internal shift registers=0, bit counter=0, ovf=0.
  - Reset mid-operation aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a and b into shift registers, load the borrow flop with bin, clear the counter, go to RUN.
  - diff and bout are not cleared at this point; they update only at the end of RUN.
- RUN, each edge processes bit i = counter (0..WIDTH-1):
  - d = a[i] ^ b[i] ^ br
  - br_next = (~a[i] & b[i]) | (~a[i] & br) | (b[i] & br)
  - d shifts into the result register from the MSB side; operand registers shift right.
  - Counter increments by 1.
  - After the edge that processes bit WIDTH-1: go to DONE, copy the result register to diff, set bout = br_next.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- busy = 1 exactly while state == RUN, i.e. WIDTH cycles.
- Latency: if start is accepted at edge k, done is high during the cycle after edge k+WIDTH.
- start is ignored in RUN and DONE; it is not queued. Minimum start-to-start spacing is WIDTH+2 cycles.
- a, b, bin may change freely after acceptance without affecting the result.
- Arithmetic is modulo 2^WIDTH. bout=1 iff unsigned a < b + bin.
- The counter must not wrap within an operation. It is sized to ceil(log2(WIDTH))+1 bits.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port exists.
  - Updated at the same edge as diff: ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operand MSBs (signed two's-complement overflow).
  - Holds until the next result; reset value 0.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, bin=0, start pulse -> busy high 8 cycles; done pulse 9 cycles after the start edge; diff=0x23, bout=0.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Accept a=0x50, b=0x20; then assert start with a=0xFF, b=0x01 during RUN and during DONE -> both ignored; single done pulse, diff=0x30, bout=0.
- Accept a=0x50, b=0x20; drive rst_n low at the 4th RUN cycle -> next cycle busy=0, done=0, diff=0, bout=0; no done pulse follows. A new start after reset gives the correct result.
- Back-to-back: start held high continuously with a=0x0A, b=0x03 -> done pulses every 10 cycles, diff=0x07 each time.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
